session_timer: RTL and testbench

Upstream of the cost converter, this block measures how long a parking session has been running. It divides the system clock into 1 s ticks and counts elapsed whole seconds into the 12-bit `sec_count` that the cost converter turns into minutes and cents. Start, stop and clear pulses from the debounced button front end control the count. The block holds the final count after stop or saturation, so cost stays stable for display and payment.

---
 rtl/session_timer.sv | 132 +++++++++++++
 tb/tb_session_timer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/session_timer.sv
// ============================================================================
//  Module      : session_timer
//  Description : Parking-session elapsed-time counter. Divides clk into 1 s
//                ticks and counts whole seconds into a saturating 12-bit
//                sec_count. Start/stop/clear pulses control an
//                IDLE/RUN/HOLD machine; the count is held after stop or
//                saturation so downstream cost stays stable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module session_timer #(
    parameter int CLK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_clear,
    output logic [11:0] sec_count,
    output logic        running,
    output logic        sat,
    output logic        session_end
);

    localparam int            PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [11:0]   SEC_LAST   = 12'd4094;   // increment from here saturates

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [11:0]   sec_q,     sec_d;
    logic          running_q, running_d;
    logic          sat_q,     sat_d;
    logic          end_q,     end_d;

    // State and counter registers; reset overrides every button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            sec_q     <= '0;
            running_q <= 1'b0;
            sat_q     <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            running_q <= running_d;
            sat_q     <= sat_d;
            end_q     <= end_d;
        end
    end

    // Next-state, prescaler and second-count logic (clear > stop > start).
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        sat_d   = sat_q;
        end_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // stop and clear have nothing to act on here, so start wins
                if (btn_start) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end

            ST_RUN: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                    sec_d   = '0;
                    presc_d = '0;
                end else if (btn_stop) begin
                    // a tick on this same edge is deliberately dropped
                    state_d = ST_HOLD;
                    presc_d = '0;
                    end_d   = 1'b1;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    sec_d   = sec_q + 12'd1;
                    if (sec_q == SEC_LAST) begin
                        state_d = ST_HOLD;
                        sat_d   = 1'b1;
                        end_d   = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            ST_HOLD: begin
                presc_d = '0;
                if (btn_clear) begin
                    state_d = ST_IDLE;
                    sec_d   = '0;
                    sat_d   = 1'b0;
                end else if (btn_start && !sat_q) begin
                    // resume; the partial second before the stop is lost
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                sec_d   = '0;
                sat_d   = 1'b0;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    assign sec_count   = sec_q;
    assign running     = running_q;
    assign sat         = sat_q;
    assign session_end = end_q;

endmodule

`default_nettype wire

// File: tb/tb_session_timer.sv
// ============================================================================
//  Module      : tb_session_timer
//  Description : Self-checking bench for session_timer (CLK_DIV=4). Directed
//                scenarios plus randomized button traffic, all compared
//                against a seconds-from-elapsed-run-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_session_timer;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        btn_start;
    logic        btn_stop;
    logic        btn_clear;
    logic [11:0] sec_count;
    logic        running;
    logic        sat;
    logic        session_end;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 run, 2 hold
    int m_mode;
    int m_sec;
    int m_base;     // seconds already accumulated when the current run began
    int m_cyc;      // cycles spent in RUN since the current run began
    bit m_sat;
    bit m_end;

    session_timer #(.CLK_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start   (btn_start),
        .btn_stop    (btn_stop),
        .btn_clear   (btn_clear),
        .sec_count   (sec_count),
        .running     (running),
        .sat         (sat),
        .session_end (session_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit s, input bit p, input bit c, input bit r);
        m_end = 1'b0;
        if (r) begin
            m_mode = 0; m_sec = 0; m_base = 0; m_cyc = 0; m_sat = 1'b0;
        end else begin
            case (m_mode)
                0: if (s) begin
                       m_mode = 1; m_base = m_sec; m_cyc = 0;
                   end
                1: if (c) begin
                       m_mode = 0; m_sec = 0;
                   end else if (p) begin
                       m_mode = 2; m_end = 1'b1;
                   end else begin
                       m_cyc++;
                       m_sec = m_base + m_cyc / DIV;
                       if (m_sec >= 4095) begin
                           m_sec = 4095; m_mode = 2; m_sat = 1'b1; m_end = 1'b1;
                       end
                   end
                default: if (c) begin
                       m_mode = 0; m_sec = 0; m_sat = 1'b0;
                   end else if (s && !m_sat) begin
                       m_mode = 1; m_base = m_sec; m_cyc = 0;
                   end
            endcase
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input bit s, input bit p, input bit c, input bit r);
        @(negedge clk);
        btn_start = s; btn_stop = p; btn_clear = c; rst = r;
        @(posedge clk);
        model_edge(s, p, c, r);
        #1;
        chk("sec_count",   32'(sec_count),   32'(m_sec));
        chk("running",     32'(running),     32'(m_mode == 1));
        chk("sat",         32'(sat),         32'(m_sat));
        chk("session_end", 32'(session_end), 32'(m_end));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        int end_pulses;
        int guard;
        rst = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
        m_mode = 0; m_sec = 0; m_base = 0; m_cyc = 0; m_sat = 0; m_end = 0;

        // reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_sec", 32'(sec_count), 0);
        chk("reset_run", 32'(running), 0);

        // basic count: start at edge 0
        step(1, 0, 0, 0);
        chk("start_running", 32'(running), 1);
        idle(3);
        chk("sec_before_4", 32'(sec_count), 0);
        idle(1);
        chk("sec_at_4", 32'(sec_count), 1);
        idle(8);
        chk("sec_at_12", 32'(sec_count), 3);
        step(0, 1, 0, 0);                       // stop at edge 13
        chk("stop_end_pulse", 32'(session_end), 1);
        chk("stop_running", 32'(running), 0);
        idle(1);
        chk("end_pulse_one_cycle", 32'(session_end), 0);
        idle(19);
        chk("hold_sec3", 32'(sec_count), 3);
        step(0, 1, 0, 0);                       // stop in HOLD ignored
        chk("stop_in_hold_no_pulse", 32'(session_end), 0);

        // stop/tick collision at 5
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        idle(20);
        chk("coll_pre_sec5", 32'(sec_count), 5);
        idle(3);
        step(0, 1, 0, 0);                       // would have ticked to 6
        chk("coll_sec_stays5", 32'(sec_count), 5);
        chk("coll_hold", 32'(running), 0);

        // resume: sec 6 exactly 4 edges after start
        idle(2);
        step(1, 0, 0, 0);
        idle(3);
        chk("resume_not_early", 32'(sec_count), 5);
        idle(1);
        chk("resume_sec6", 32'(sec_count), 6);
        step(0, 0, 1, 0);
        chk("clear_sec0", 32'(sec_count), 0);
        chk("clear_run0", 32'(running), 0);

        // saturation
        step(1, 0, 0, 0);
        guard = 0;
        while (m_sec < 4094 && guard < 20000) begin
            idle(1);
            guard++;
        end
        chk("reach_4094", 32'(sec_count), 4094);
        end_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (session_end) end_pulses++;
        end
        chk("sat_sec", 32'(sec_count), 4095);
        chk("sat_flag", 32'(sat), 1);
        chk("sat_one_pulse", 32'(end_pulses), 1);
        step(1, 0, 0, 0);
        chk("sat_start_ignored", 32'(running), 0);
        idle(6);
        chk("sat_no_wrap", 32'(sec_count), 4095);
        step(0, 0, 1, 0);
        chk("sat_clear", 32'(sat), 0);

        // simultaneous pulses
        step(1, 0, 0, 0);
        idle(6);
        step(1, 1, 1, 0);
        chk("all3_sec0", 32'(sec_count), 0);
        chk("all3_idle", 32'(running), 0);
        step(1, 1, 0, 0);
        chk("start_stop_idle_run", 32'(running), 1);

        // reset mid-RUN at 17
        while (m_sec < 17) idle(1);
        chk("pre_rst_17", 32'(sec_count), 17);
        step(1, 1, 1, 1);
        chk("rst_sec", 32'(sec_count), 0);
        chk("rst_running", 32'(running), 0);
        step(1, 0, 0, 1);
        chk("rst_ignores_start", 32'(running), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit s, p, c, r;
            s = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 29) == 0);
            c = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 299) == 0);
            step(s, p, c, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
